fright_timer: RTL and testbench

Power-pellet consumer placed directly downstream of the pellet-eating logic. Takes the pellet stage's `start_the_count` strobe and runs the frightened-mode window: a frame-based countdown with a warning (flashing) phase, a per-ghost vulnerability mask, and the 200/400/800/1600 ghost-eating bonus chain. Its outputs drive the ghost AI and sprite palette, and provide a bonus stream to the score keeper.

---
 rtl/pacman_pkg.sv | 28 ++
 rtl/ghost_bonus_chain.sv | 52 +++++
 rtl/fright_timer.sv | 124 ++++++++++++
 tb/tb_fright_timer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared Pac-Man game-logic types and constants.
// Holds the frightened-mode state type, the ghost indices and the bonus value helper.
package pacman_pkg;

    localparam int NUM_GHOSTS       = 4;
    localparam int GHOST_BONUS_BASE = 200;
    localparam int BONUS_W          = 11;
    localparam int CHAIN_W          = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRIGHT = 2'd1,
        FLASH  = 2'd2
    } fright_state_t;

    typedef enum logic [1:0] {
        GHOST_BLINKY = 2'd0,
        GHOST_PINKY  = 2'd1,
        GHOST_INKY   = 2'd2,
        GHOST_CLYDE  = 2'd3
    } ghost_id_t;

    // Chain position 0..3 pays 200, 400, 800, 1600.
    function automatic logic [BONUS_W-1:0] bonus_for_chain(input logic [CHAIN_W-1:0] chain);
        return BONUS_W'(GHOST_BONUS_BASE) << chain;
    endfunction

endpackage

// File: rtl/ghost_bonus_chain.sv
// Collects eaten ghosts into a pending mask and pays them out one per cycle,
// lowest index first, on a doubling 200..1600 chain.
module ghost_bonus_chain
    import pacman_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  clear,
    input  logic [NUM_GHOSTS-1:0] set_mask,
    output logic                  bonus_valid,
    output logic [BONUS_W-1:0]    bonus_points,
    output logic                  pending_empty
);

    logic [NUM_GHOSTS-1:0] pending;
    logic [NUM_GHOSTS-1:0] merged;
    logic [NUM_GHOSTS-1:0] drain_sel;
    logic [CHAIN_W-1:0]    chain;

    function automatic logic [CHAIN_W-1:0] chain_sat_inc(input logic [CHAIN_W-1:0] c);
        return (c == '1) ? c : c + CHAIN_W'(1);
    endfunction

    // Ghosts eaten this cycle can drain immediately, giving a one-cycle bonus latency.
    assign merged        = pending | set_mask;
    assign drain_sel     = merged & (~merged + NUM_GHOSTS'(1));
    assign pending_empty = (pending == '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pending      <= '0;
            chain        <= '0;
            bonus_valid  <= 1'b0;
            bonus_points <= '0;
        end else if (clear) begin
            pending      <= '0;
            chain        <= '0;
            bonus_valid  <= 1'b0;
            bonus_points <= '0;
        end else begin
            pending     <= merged & ~drain_sel;
            bonus_valid <= |merged;
            if (|merged) begin
                bonus_points <= bonus_for_chain(chain);
                chain        <= chain_sat_inc(chain);
            end else begin
                bonus_points <= '0;
            end
        end
    end

endmodule

// File: rtl/fright_timer.sv
// Frightened-mode window after a power pellet: frame countdown, flashing phase,
// per-ghost vulnerability mask and the ghost-eating bonus stream.
module fright_timer
    import pacman_pkg::*;
#(
    parameter int FRIGHT_FRAMES = 360,
    parameter int FLASH_FRAMES  = 120,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_tick,
    input  logic                  start_the_count,
    input  logic [NUM_GHOSTS-1:0] ghost_eaten,
    output logic                  frightened,
    output logic                  flashing,
    output logic                  blink,
    output logic [NUM_GHOSTS-1:0] ghost_vuln,
    output logic                  bonus_valid,
    output logic [BONUS_W-1:0]    bonus_points
);

    localparam int CNT_W = $clog2(FRIGHT_FRAMES + 1);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FRIGHT_FRAMES);
    localparam logic [CNT_W-1:0] CNT_FLASH = CNT_W'(FLASH_FRAMES);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    fright_state_t         state, state_n;
    logic [CNT_W-1:0]      count, count_n, count_dec;
    logic [BLK_W-1:0]      blk_cnt, blk_cnt_n;
    logic                  blink_q, blink_n;
    logic [NUM_GHOSTS-1:0] vuln_n;
    logic [NUM_GHOSTS-1:0] eat_mask;
    logic                  start_p1;
    logic                  start_ev;
    logic                  pend_empty;

    assign start_ev  = start_the_count & ~start_p1;
    // A start in the same cycle as a collision wins: the collision is dropped.
    assign eat_mask  = (state != IDLE && !start_ev) ? (ghost_eaten & ghost_vuln) : '0;
    assign count_dec = (count != '0) ? count - CNT_W'(1) : count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            count      <= '0;
            blk_cnt    <= '0;
            blink_q    <= 1'b0;
            ghost_vuln <= '0;
            start_p1   <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            blk_cnt    <= blk_cnt_n;
            blink_q    <= blink_n;
            ghost_vuln <= vuln_n;
            start_p1   <= start_the_count;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        blk_cnt_n = blk_cnt;
        blink_n   = blink_q;
        vuln_n    = ghost_vuln & ~eat_mask;
        if (start_ev) begin
            state_n   = FRIGHT;
            count_n   = CNT_LOAD;
            vuln_n    = '1;
            blink_n   = 1'b0;
            blk_cnt_n = '0;
        end else if (state != IDLE && ghost_vuln == '0 && pend_empty) begin
            // Every ghost eaten and paid: the window ends early.
            state_n   = IDLE;
            count_n   = '0;
            blink_n   = 1'b0;
            blk_cnt_n = '0;
        end else if (frame_tick) begin
            case (state)
                FRIGHT: begin
                    count_n = count_dec;
                    if (count_dec == CNT_FLASH) begin
                        state_n   = FLASH;
                        blink_n   = 1'b1;
                        blk_cnt_n = '0;
                    end
                end
                FLASH: begin
                    count_n = count_dec;
                    if (blk_cnt == BLK_LAST) begin
                        blk_cnt_n = '0;
                        blink_n   = ~blink_q;
                    end else begin
                        blk_cnt_n = blk_cnt + BLK_W'(1);
                    end
                    if (count_dec == '0) begin
                        state_n   = IDLE;
                        vuln_n    = '0;
                        blink_n   = 1'b0;
                        blk_cnt_n = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign frightened = (state != IDLE);
    assign flashing   = (state == FLASH);
    assign blink      = blink_q & flashing;

    ghost_bonus_chain u_chain (
        .Clk           (Clk),
        .Reset         (Reset),
        .clear         (start_ev),
        .set_mask      (eat_mask),
        .bonus_valid   (bonus_valid),
        .bonus_points  (bonus_points),
        .pending_empty (pend_empty)
    );

endmodule

// File: tb/tb_fright_timer.sv
// Bench for fright_timer: directed scenarios plus a random phase, all checked
// every cycle against a tick-counting reference model with a queue of owed bonuses.
module tb_fright_timer;

    localparam int FR = 360;
    localparam int FL = 120;
    localparam int BL = 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic        start_the_count;
    logic [3:0]  ghost_eaten;
    logic        frightened;
    logic        flashing;
    logic        blink;
    logic [3:0]  ghost_vuln;
    logic        bonus_valid;
    logic [10:0] bonus_points;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: window active flag, ticks seen since the start event,
    // vulnerable set, awards paid in this window and a queue of ghosts owed a bonus.
    bit         m_prev_start;
    bit         m_on;
    int         m_ticks;
    int         m_awards;
    logic [3:0] m_vuln;
    int         pay_q[$];
    bit         e_valid;
    int         e_points;

    fright_timer #(.FRIGHT_FRAMES(FR), .FLASH_FRAMES(FL), .BLINK_FRAMES(BL)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .frame_tick      (frame_tick),
        .start_the_count (start_the_count),
        .ghost_eaten     (ghost_eaten),
        .frightened      (frightened),
        .flashing        (flashing),
        .blink           (blink),
        .ghost_vuln      (ghost_vuln),
        .bonus_valid     (bonus_valid),
        .bonus_points    (bonus_points)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_start = 1'b0;
        m_on         = 1'b0;
        m_ticks      = 0;
        m_awards     = 0;
        m_vuln       = 4'h0;
        e_valid      = 1'b0;
        e_points     = 0;
        pay_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        bit exp_fl;
        bit exp_blk;
        exp_fl  = m_on && (m_ticks >= FR - FL);
        exp_blk = exp_fl && ((((m_ticks - (FR - FL)) / BL) % 2) == 0);
        chk({tag, ".frightened"}, {31'd0, frightened}, {31'd0, m_on});
        chk({tag, ".flashing"}, {31'd0, flashing}, {31'd0, exp_fl});
        chk({tag, ".blink"}, {31'd0, blink}, {31'd0, exp_blk});
        chk({tag, ".ghost_vuln"}, {28'd0, ghost_vuln}, {28'd0, m_vuln});
        chk({tag, ".bonus_valid"}, {31'd0, bonus_valid}, {31'd0, e_valid});
        if (e_valid)
            chk({tag, ".bonus_points"}, {21'd0, bonus_points}, e_points);
    endtask

    // One clock cycle: apply inputs, advance the model by the same cycle, check.
    task automatic step(input bit st, input bit tk, input logic [3:0] eat, input string tag);
        bit         sev;
        bit         early;
        logic [3:0] got;
        int         lvl;
        start_the_count = st;
        frame_tick      = tk;
        ghost_eaten     = eat;
        @(posedge Clk);
        sev          = st && !m_prev_start;
        m_prev_start = st;
        if (sev) begin
            m_on     = 1'b1;
            m_ticks  = 0;
            m_vuln   = 4'hF;
            m_awards = 0;
            pay_q.delete();
            e_valid  = 1'b0;
        end else begin
            early = m_on && (m_vuln == 4'h0) && (pay_q.size() == 0);
            if (m_on) begin
                got = eat & m_vuln;
                for (int i = 0; i < 4; i++)
                    if (got[i]) pay_q.push_back(i);
                m_vuln = m_vuln & ~got;
            end
            if (early) begin
                m_on = 1'b0;
            end else if (m_on && tk) begin
                m_ticks++;
                if (m_ticks >= FR) begin
                    m_on   = 1'b0;
                    m_vuln = 4'h0;
                end
            end
            if (pay_q.size() > 0) begin
                void'(pay_q.pop_front());
                lvl      = (m_awards > 3) ? 3 : m_awards;
                e_valid  = 1'b1;
                e_points = 200 * (1 << lvl);
                m_awards++;
            end else begin
                e_valid = 1'b0;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic ticks(input int n, input int gap, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 4'h0, tag);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 4'h0, tag);
        end
    endtask

    initial begin
        Reset           = 1'b1;
        frame_tick      = 1'b0;
        start_the_count = 1'b0;
        ghost_eaten     = 4'h0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk("reset.frightened", {31'd0, frightened}, 32'd0);
        chk("reset.flashing", {31'd0, flashing}, 32'd0);
        chk("reset.blink", {31'd0, blink}, 32'd0);
        chk("reset.ghost_vuln", {28'd0, ghost_vuln}, 32'd0);
        chk("reset.bonus_valid", {31'd0, bonus_valid}, 32'd0);
        chk("reset.bonus_points", {21'd0, bonus_points}, 32'd0);
        Reset = 1'b0;

        // Basic window: start, then 360 ticks spaced out, no eats.
        step(1'b1, 1'b0, 4'h0, "basic.start");
        chk("basic.frightened_after_start", {31'd0, frightened}, 32'd1);
        chk("basic.vuln_after_start", {28'd0, ghost_vuln}, 32'hF);
        ticks(240, 1, "basic.fright");
        chk("basic.flash_at_240", {31'd0, flashing}, 32'd1);
        ticks(120, 1, "basic.flash");
        chk("basic.off_after_360", {31'd0, frightened}, 32'd0);
        ticks(3, 0, "basic.idle");

        // Held start (and tick in the start cycle), then four single eats.
        step(1'b1, 1'b1, 4'h0, "held.start");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'h0, "held.level");
        step(1'b0, 1'b0, 4'h0, "held.release");
        ticks(10, 0, "held.run");
        step(1'b0, 1'b0, 4'b0100, "single.eat2");
        step(1'b0, 1'b1, 4'h0, "single.gap");
        chk("single.first_pays_400_next", {31'd0, bonus_valid}, 32'd0);
        step(1'b0, 1'b0, 4'b0001, "single.eat0");
        chk("single.pay400", {21'd0, bonus_points}, 32'd400);
        step(1'b0, 1'b0, 4'b1000, "single.eat3");
        step(1'b0, 1'b0, 4'b0010, "single.eat1");
        chk("single.pay1600", {21'd0, bonus_points}, 32'd1600);
        chk("single.vuln_empty", {28'd0, ghost_vuln}, 32'd0);
        ticks(3, 0, "single.early_end");
        chk("single.idle_early", {31'd0, frightened}, 32'd0);

        // Simultaneous eat of all four.
        step(1'b1, 1'b0, 4'h0, "simul.start");
        step(1'b0, 1'b1, 4'h0, "simul.run");
        step(1'b0, 1'b0, 4'hF, "simul.eat_all");
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 4'h0, "simul.drain");

        // Second pellet in FLASH at count 100.
        step(1'b0, 1'b0, 4'h0, "reeat.low");
        step(1'b1, 1'b0, 4'h0, "reeat.start");
        step(1'b0, 1'b0, 4'h0, "reeat.low2");
        ticks(260, 0, "reeat.run");
        step(1'b0, 1'b0, 4'b0010, "reeat.eat1");
        step(1'b0, 1'b0, 4'b0010, "reeat.eat1_again");
        step(1'b1, 1'b0, 4'b0100, "reeat.restart_with_eat");
        chk("reeat.vuln_reload", {28'd0, ghost_vuln}, 32'hF);
        chk("reeat.back_to_fright", {31'd0, flashing}, 32'd0);
        step(1'b0, 1'b0, 4'h0, "reeat.low3");
        step(1'b0, 1'b0, 4'b1000, "reeat.eat3");
        chk("reeat.pays200", {21'd0, bonus_points}, 32'd200);

        // Expiry tick and an eat in the same cycle.
        step(1'b0, 1'b0, 4'h0, "expiry.low");
        step(1'b1, 1'b0, 4'h0, "expiry.start");
        ticks(359, 0, "expiry.run");
        step(1'b0, 1'b1, 4'b0001, "expiry.last_tick_eat");
        chk("expiry.paid_after_end", {31'd0, bonus_valid}, 32'd1);
        chk("expiry.ended", {31'd0, frightened}, 32'd0);
        ticks(2, 0, "expiry.idle");
        step(1'b0, 1'b0, 4'hF, "expiry.eat_in_idle");

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 14) == 0) ? 4'($urandom) : 4'h0, "random");
        end

        // Asynchronous reset mid-FLASH with two bonuses still owed.
        step(1'b0, 1'b0, 4'h0, "areset.low");
        step(1'b1, 1'b0, 4'h0, "areset.start");
        step(1'b0, 1'b0, 4'h0, "areset.low2");
        ticks(250, 0, "areset.run");
        step(1'b0, 1'b0, 4'b0111, "areset.eat3");
        start_the_count = 1'b0;
        frame_tick      = 1'b0;
        ghost_eaten     = 4'h0;
        #3;
        Reset = 1'b1;
        #1;
        chk("areset.frightened", {31'd0, frightened}, 32'd0);
        chk("areset.flashing", {31'd0, flashing}, 32'd0);
        chk("areset.blink", {31'd0, blink}, 32'd0);
        chk("areset.ghost_vuln", {28'd0, ghost_vuln}, 32'd0);
        chk("areset.bonus_valid", {31'd0, bonus_valid}, 32'd0);
        chk("areset.bonus_points", {21'd0, bonus_points}, 32'd0);
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'h0, "areset.after");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
